// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store.
// Latency: grant at t, mem_req at t+1, data_ok in the cycle mem_data_ok arrives in DATA.
// Backpressure: one transaction at a time; requesters hold req until their addr_ok pulse.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   inst_req/addr -> inst_addr_ok    fetch request and accept pulse
//   inst_data_ok, inst_rdata         fetch completion pulse and data
//   data_req/wr/wen/addr/wdata       load/store request, data_addr_ok accept pulse
//   data_data_ok, data_rdata         load/store completion pulse and data
//   flush                            pipeline clear; blocks and discards fetches only
//   mem_*                            shared memory port (request out, responses in)
//   busy                             a transaction is in progress
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner_data;
  logic        r_wr;
  logic [3:0]  r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_starve;
  logic        r_discard;

  logic w_idle;
  logic w_inst_elig;
  logic w_force_inst;
  logic w_grant_data;
  logic w_grant_inst;
  logic w_done;

  // Pulses are suppressed while reset is asserted so an abandoned transaction
  // never reports completion.
  assign w_idle       = (r_state == S_IDLE);
  assign w_inst_elig  = inst_req & ~flush;
  assign w_force_inst = w_inst_elig & (r_starve == 4'(STARVE_LIMIT));
  assign w_grant_data = rst_n & w_idle & data_req & ~w_force_inst;
  assign w_grant_inst = rst_n & w_idle & w_inst_elig & ~w_grant_data;
  assign w_done       = rst_n & (r_state == S_DATA) & mem_data_ok;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; mem_data_ok seen in ADDR is ignored
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_data | w_grant_inst) w_state_nxt = S_ADDR;
      S_ADDR:  if (mem_addr_ok)                 w_state_nxt = S_DATA;
      S_DATA:  if (mem_data_ok)                 w_state_nxt = S_IDLE;
      default:                                  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    inst_addr_ok = w_grant_inst;
    data_addr_ok = w_grant_data;
    mem_req      = (r_state == S_ADDR);
    mem_wr       = (r_state == S_ADDR) & r_wr;
    // A fetch flushed during the transaction, or in its completion cycle, is dropped
    inst_data_ok = w_done & ~r_owner_data & ~r_discard & ~flush;
    data_data_ok = w_done & r_owner_data;
    busy         = ~w_idle;
  end

  assign mem_wen    = r_wen;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  // Latched request, starvation counter, discard flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner_data <= 1'b0;
      r_wr         <= 1'b0;
      r_wen        <= 4'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_starve     <= 4'd0;
      r_discard    <= 1'b0;
    end else begin
      if (w_grant_data | w_grant_inst) begin
        r_owner_data <= w_grant_data;
        r_wr         <= w_grant_data & data_wr;
        r_wen        <= w_grant_data ? data_wen   : 4'd0;
        r_addr       <= w_grant_data ? data_addr  : inst_addr;
        r_wdata      <= w_grant_data ? data_wdata : 32'd0;
      end
      // Counter only moves on IDLE decisions; it counts data wins over a waiting fetch
      if (w_idle) begin
        if (w_grant_inst | ~inst_req)
          r_starve <= 4'd0;
        else if (w_grant_data && (r_starve != 4'(STARVE_LIMIT)))
          r_starve <= r_starve + 4'd1;
      end
      if (w_idle | w_done)
        r_discard <= 1'b0;
      else if (flush & ~r_owner_data)
        r_discard <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        flush;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, busy;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .flush(flush),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
    flush = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    nxt();
    nxt();
    rst_n = 1;
  endtask

  // Transaction-level reference: one outstanding transaction record plus
  // the fairness count and a "results will be dropped" mark.
  logic        m_busy, m_acc, m_od, m_wr, m_disc;
  logic [3:0]  m_wen;
  logic [31:0] m_addr, m_wd;
  int          m_starve;

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_od = 0; m_wr = 0; m_disc = 0;
    m_wen = 0; m_addr = 0; m_wd = 0; m_starve = 0;
  endtask

  typedef struct {
    logic ir, dr, fl, e_ia, e_da;
  } vec_t;
  vec_t tbl [7];

  int   n_ok;
  logic ip, dp;

  initial begin
    rst_n = 0;
    idle_inputs();

    // ---- reset state ----
    do_reset();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_pulses", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    nxt();

    // ---- IDLE selection table from a cleared counter ----
    tbl[0] = '{0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 1, 0};
    tbl[2] = '{0, 1, 0, 0, 1};
    tbl[3] = '{1, 1, 0, 0, 1};
    tbl[4] = '{1, 0, 1, 0, 0};
    tbl[5] = '{1, 1, 1, 0, 1};
    tbl[6] = '{0, 1, 1, 0, 1};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      inst_req = tbl[i].ir; data_req = tbl[i].dr; flush = tbl[i].fl;
      inst_addr = 32'h100 + i; data_addr = 32'h200 + i;
      @(negedge clk);
      chk($sformatf("vec%0d_inst_addr_ok", i), inst_addr_ok, tbl[i].e_ia);
      chk($sformatf("vec%0d_data_addr_ok", i), data_addr_ok, tbl[i].e_da);
      nxt();
      inst_req = 0; data_req = 0; flush = 0;
      @(negedge clk);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_ia | tbl[i].e_da);
      chk($sformatf("vec%0d_mem_req", i), mem_req, tbl[i].e_ia | tbl[i].e_da);
      chk($sformatf("vec%0d_mem_addr", i), mem_addr,
          tbl[i].e_da ? 32'h200 + i : (tbl[i].e_ia ? 32'h100 + i : 32'h0));
      nxt();
    end

    // ---- starvation: both held, port answers immediately ----
    begin
      int    g;
      string kinds;
      g = 0;
      kinds = "";
      do_reset();
      inst_req = 1; inst_addr = 32'hBFC0_0000;
      data_req = 1; data_addr = 32'h0000_4000;
      mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hA5A5_0001;
      for (int c = 0; c < 40 && g < 6; c++) begin
        @(negedge clk);
        if (c == 1) begin
          chk("lat_mem_req_t1", mem_req, 1);
          chk("lat_mem_addr_t1", mem_addr, 32'h0000_4000);
        end
        if (c == 2) begin
          chk("lat_data_ok_t2", data_data_ok, 1);
          chk("lat_data_rdata", data_rdata, 32'hA5A5_0001);
        end
        if (inst_addr_ok || data_addr_ok) begin
          chk($sformatf("starve_grant%0d_cycle", g), c, 3 * g);
          kinds = {kinds, data_addr_ok ? "d" : "i"};
          g++;
        end
      end
      chk("starve_grant_count", g, 6);
      chk("starve_order_ddddid", kinds == "ddddid", 1);
      nxt();
    end

    // ---- store with late addr_ok and late data_ok ----
    begin
      do_reset();
      n_ok = 0;
      data_req = 1; data_wr = 1; data_wen = 4'b0011;
      data_addr = 32'h1FC0_0010; data_wdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("st_addr_ok", data_addr_ok, 1);
      nxt();
      data_req = 0; data_wr = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
      for (int c = 1; c <= 6; c++) begin
        mem_addr_ok = (c == 2);
        mem_data_ok = (c == 4);
        @(negedge clk);
        if (data_data_ok) n_ok++;
        chk($sformatf("st_c%0d_inst_ok", c), {inst_addr_ok, inst_data_ok}, 0);
        if (c <= 2) begin
          chk($sformatf("st_c%0d_mem_req", c), mem_req, 1);
          chk($sformatf("st_c%0d_mem_attr", c),
              {mem_wr, mem_wen, mem_addr, mem_wdata[15:0]}, {1'b1, 4'b0011, 32'h1FC0_0010, 16'hBEEF});
          chk($sformatf("st_c%0d_mem_wdata", c), mem_wdata, 32'hDEADBEEF);
        end
        if (c == 3) chk("st_c3_mem_req_low", mem_req, 0);
        if (c == 4) chk("st_c4_data_ok", data_data_ok, 1);
        if (c == 5) chk("st_c5_idle", busy, 0);
        nxt();
      end
      chk("st_data_ok_once", n_ok, 1);
    end

    // ---- fetch flushed in DATA is discarded, next request still served ----
    begin
      do_reset();
      inst_req = 1; inst_addr = 32'hBFC0_0100;
      @(negedge clk);
      chk("fl_inst_addr_ok", inst_addr_ok, 1);
      nxt();
      inst_req = 0; mem_addr_ok = 1;
      @(negedge clk);
      nxt();
      mem_addr_ok = 0; flush = 1;
      @(negedge clk);
      chk("fl_data_phase", {busy, mem_req, inst_data_ok}, 3'b100);
      nxt();
      flush = 0; mem_data_ok = 1; mem_rdata = 32'h12345678;
      @(negedge clk);
      chk("fl_inst_data_ok_dropped", inst_data_ok, 0);
      chk("fl_inst_rdata", inst_rdata, 32'h12345678);
      chk("fl_data_rdata", data_rdata, 32'h12345678);
      nxt();
      mem_data_ok = 0; data_req = 1; data_addr = 32'h0000_0080;
      @(negedge clk);
      chk("fl_back_idle", busy, 0);
      chk("fl_next_grant", data_addr_ok, 1);
      nxt();
      data_req = 0;
    end

    // ---- flush in IDLE blocks a lone fetch for that cycle only ----
    begin
      do_reset();
      inst_req = 1; inst_addr = 32'hBFC0_0200; flush = 1;
      @(negedge clk);
      chk("fi_blocked", inst_addr_ok, 0);
      nxt();
      flush = 0;
      @(negedge clk);
      chk("fi_granted", inst_addr_ok, 1);
      nxt();
      inst_req = 0;
    end

    // ---- reset during ADDR abandons the transaction silently ----
    begin
      do_reset();
      n_ok = 0;
      data_req = 1; data_addr = 32'h0000_0300;
      @(negedge clk);
      chk("ra_grant", data_addr_ok, 1);
      nxt();
      data_req = 0; rst_n = 0; mem_data_ok = 1;
      @(negedge clk);
      if (inst_data_ok || data_data_ok) n_ok++;
      nxt();
      @(negedge clk);
      chk("ra_busy", busy, 0);
      chk("ra_mem_req", mem_req, 0);
      nxt();
      rst_n = 1; mem_addr_ok = 1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (inst_data_ok || data_data_ok) n_ok++;
        nxt();
      end
      chk("ra_no_data_ok", n_ok, 0);
    end

    // ---- randomized traffic against the transaction model ----
    begin
      logic e_ia, e_da, e_id, e_dd, ie, fi;
      do_reset();
      model_reset();
      ip = 0; dp = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (!ip && ($urandom % 3 == 0)) begin
          ip = 1; inst_addr = $urandom;
        end
        if (!dp && ($urandom % 3 == 0)) begin
          dp = 1; data_wr = $urandom % 2; data_wen = $urandom; data_addr = $urandom; data_wdata = $urandom;
        end
        inst_req = ip; data_req = dp;
        flush = ($urandom % 8 == 0);
        mem_addr_ok = $urandom % 2;
        mem_data_ok = $urandom % 2;
        mem_rdata = $urandom;
        rst_n = !($urandom % 150 == 0);
        @(negedge clk);
        e_ia = 0; e_da = 0; e_id = 0; e_dd = 0;
        if (rst_n) begin
          if (!m_busy) begin
            ie = inst_req && !flush;
            fi = ie && (m_starve == LIM);
            e_da = data_req && !fi;
            e_ia = ie && !e_da;
          end else if (m_acc && mem_data_ok) begin
            if (m_od) e_dd = 1;
            else      e_id = !(m_disc || flush);
          end
        end
        chk("rnd_inst_addr_ok", inst_addr_ok, e_ia);
        chk("rnd_data_addr_ok", data_addr_ok, e_da);
        chk("rnd_inst_data_ok", inst_data_ok, e_id);
        chk("rnd_data_data_ok", data_data_ok, e_dd);
        chk("rnd_busy", busy, m_busy);
        chk("rnd_mem_req", mem_req, m_busy && !m_acc);
        chk("rnd_mem_wr", mem_wr, m_busy && !m_acc && m_wr);
        if (m_busy && !m_acc) chk("rnd_mem_addr", mem_addr, m_addr);
        if (m_busy && !m_acc && m_od) chk("rnd_mem_wen_wdata", {mem_wen, mem_wdata}, {m_wen, m_wd});
        chk("rnd_rdata", {inst_rdata, data_rdata}, {mem_rdata, mem_rdata});
        // advance the reference to the next cycle
        if (!rst_n) begin
          model_reset();
        end else if (!m_busy) begin
          if (e_da || e_ia) begin
            m_busy = 1; m_acc = 0; m_od = e_da; m_disc = 0;
            m_wr   = e_da && data_wr;
            m_wen  = e_da ? data_wen : 4'd0;
            m_addr = e_da ? data_addr : inst_addr;
            m_wd   = e_da ? data_wdata : 32'd0;
          end
          if (e_ia || !inst_req) m_starve = 0;
          else if (e_da)         m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
        end else begin
          if (flush && !m_od) m_disc = 1;
          if (!m_acc) begin
            if (mem_addr_ok) m_acc = 1;
          end else if (mem_data_ok) begin
            m_busy = 0; m_disc = 0;
          end
        end
        if (e_ia) ip = 0;
        if (e_da) dp = 0;
        nxt();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, sets the number of consecutive data grants while inst waits before inst is forced ahead; legal range 1..15.
REQ-002 The clock is clk, and reset is rst_n, synchronous, active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 inst_req  in  1  fetch read request, held until inst_addr_ok.
REQ-006 inst_addr  in  32  fetch physical address.
REQ-007 inst_addr_ok  out  1  fetch request accepted (one-cycle pulse).
REQ-008 inst_data_ok  out  1  fetch read data valid (one-cycle pulse).
REQ-009 inst_rdata  out  32  fetch read data.
REQ-010 data_req  in  1  load/store request, held until data_addr_ok.
REQ-011 data_wr  in  1  1 = store, 0 = load.
REQ-012 data_wen  in  4  store byte enables.
REQ-013 data_addr  in  32  load/store physical address.
REQ-014 data_wdata  in  32  store data.
REQ-015 data_addr_ok  out  1  load/store accepted (pulse).
REQ-016 data_data_ok  out  1  load data valid or store done (pulse).
REQ-017 data_rdata  out  32  load data.
REQ-018 flush  in  1  pipeline clear (exception/eret) from WB.
REQ-019 mem_req, mem_wr  out  1 each  shared-port request and write flag.
REQ-020 mem_wen  out  4;  mem_addr, mem_wdata  out  32 each  shared-port attributes.
REQ-021 mem_addr_ok, mem_data_ok  in  1 each;  mem_rdata  in  32  shared-port responses.
REQ-022 busy  out  1  transaction in progress.

Function
REQ-023 The FSM SHALL have exactly three states: IDLE, ADDR and DATA; busy SHALL be 1 whenever the state is not IDLE.
REQ-024 The arbiter SHALL hold at most one transaction outstanding on the shared port.
REQ-025 In IDLE, when a request is selected, the block SHALL latch owner/wr/wen/addr/wdata, pulse that requester's addr_ok in the same cycle, and enter ADDR.
REQ-026 Selection: data over inst, except when the starvation counter equals STARVE_LIMIT and inst_req=1, in which case inst wins.
REQ-027 Starvation counter (4 bits): +1 when data is granted while inst_req=1; cleared to 0 on an inst grant or when inst_req=0 in IDLE; saturates at STARVE_LIMIT.
REQ-028 In IDLE with flush=1, inst_req SHALL NOT be granted, and a data request SHALL still be granted.
REQ-029 mem_req SHALL be 1 only in ADDR, with mem_wr/mem_wen/mem_addr/mem_wdata driven from the latched registers, stable until mem_addr_ok.
REQ-030 ADDR with mem_addr_ok=1 SHALL go to DATA next cycle; a mem_data_ok received in ADDR SHALL be ignored.
REQ-031 In DATA, on mem_data_ok=1 the owner's data_ok SHALL pulse in the same cycle with rdata = mem_rdata (combinational), and the FSM SHALL return to IDLE.
REQ-032 flush=1 while the owner is inst in ADDR or DATA SHALL set a discard flag; the transaction SHALL complete on the port but inst_data_ok SHALL stay 0; the flag SHALL clear on return to IDLE.
REQ-033 flush SHALL NOT affect data-owner transactions: stores and loads SHALL complete and pulse data_data_ok.
REQ-034 Latency: grant at cycle t, mem_req at t+1; if mem_addr_ok is at t+1 and mem_data_ok at t+2, data_ok SHALL be at t+2; the next grant SHALL be possible at t+3.
REQ-035 addr_ok and data_ok pulses SHALL never be asserted for both requesters in the same cycle.
REQ-036 inst_rdata and data_rdata SHALL both equal mem_rdata at all times; validity is indicated only by data_ok.

Reset
REQ-037 With rst_n=0 at a clock edge: state=IDLE, counter=0, discard=0, latched registers=0; mem_req, mem_wr, busy and all addr_ok/data_ok pulses SHALL be 0 from the next cycle.
REQ-038 Reset mid-transaction SHALL abandon the transaction without emitting any data_ok.

Verification
REQ-039 Scenario: inst_req and data_req both 1 in IDLE, counter=0 -> data_addr_ok=1, then mem_req=1 with mem_addr=data_addr; inst waits.
REQ-040 Scenario: inst_req held, data_req continuous, STARVE_LIMIT=4 -> 4 data grants, then the 5th grant is inst, and the counter returns to 0.
REQ-041 Scenario: store wen=4'b0011, addr 0x1FC0_0010, wdata 0xDEADBEEF; mem_addr_ok and mem_data_ok each 1 cycle late -> mem_wen/mem_addr/mem_wdata match, and data_data_ok pulses once.
REQ-042 Scenario: inst load in DATA, flush=1, then mem_data_ok with rdata 0x12345678 -> inst_data_ok stays 0, FSM goes to IDLE, and the next request is granted.
REQ-043 Scenario: flush=1 in IDLE with only inst_req -> no inst_addr_ok; with flush=0 next cycle -> inst_addr_ok=1.
REQ-044 Scenario: rst_n=0 asserted in ADDR -> next cycle busy=0 and mem_req=0, with no data_ok pulse ever seen for that transaction.
